// File: rtl/regfile_sb_pkg.sv
// ============================================================================
// regfile_sb_pkg : shared defaults and constants for the scoreboarded regfile
// Revision: 1.0
// ============================================================================
`default_nettype none

package regfile_sb_pkg;
    localparam int RF_XLEN_DEFAULT  = 32;
    localparam int RF_NREGS_DEFAULT = 16;
    localparam int RF_REG_ZERO      = 0;
    localparam int RF_RESET_VALUE   = 0;
endpackage

`default_nettype wire

// File: rtl/rf_scoreboard.sv
// ============================================================================
// rf_scoreboard : per-register busy bits with alloc-over-clear priority and
//                 a sticky error flag for writes to non-busy registers.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rf_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int NREGS = RF_NREGS_DEFAULT,
    parameter int NWR   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_en,
    input  logic [AW-1:0]     alloc_addr,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    output logic [NREGS-1:0]  busy,
    output logic              wb_err
);

    localparam logic [AW-1:0] c_zero_addr = AW'(RF_REG_ZERO);

    logic [NREGS-1:0] r_busy;
    logic             r_err;
    logic [NREGS-1:0] w_busy_nxt;
    logic             w_err_hit;
    logic [AW-1:0]    w_wr_addr [NWR];

    for (genvar g = 0; g < NWR; g++) begin : g_wr_addr
        assign w_wr_addr[g] = wr_addr[g*AW +: AW];
    end

    // Error is judged against the pre-edge busy state; an alloc to the same
    // register in the same cycle legitimises the write.
    always_comb begin
        w_busy_nxt = r_busy;
        w_err_hit  = 1'b0;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w]) begin
                if (w_wr_addr[w] != c_zero_addr && !r_busy[w_wr_addr[w]] &&
                    !(alloc_en && alloc_addr == w_wr_addr[w])) begin
                    w_err_hit = 1'b1;
                end
                w_busy_nxt[w_wr_addr[w]] = 1'b0;
            end
        end
        if (alloc_en) begin
            w_busy_nxt[alloc_addr] = 1'b1;
        end
        w_busy_nxt[RF_REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_err  <= r_err | w_err_hit;
        end
    end

    assign busy   = r_busy;
    assign wb_err = r_err;

endmodule

`default_nettype wire

// File: rtl/regfile_sb.sv
// ============================================================================
// regfile_sb : multi-port register file with write bypass and busy scoreboard
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int XLEN  = RF_XLEN_DEFAULT,
    parameter int NREGS = RF_NREGS_DEFAULT,
    parameter int NRD   = 2,
    parameter int NWR   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NRD*$clog2(NREGS)-1:0] rd_addr,
    output logic [NRD*XLEN-1:0]          rd_data,
    output logic [NRD-1:0]               rd_busy,
    input  logic [NWR-1:0]               wr_en,
    input  logic [NWR*$clog2(NREGS)-1:0] wr_addr,
    input  logic [NWR*XLEN-1:0]          wr_data,
    input  logic                         alloc_en,
    input  logic [$clog2(NREGS)-1:0]     alloc_addr,
    output logic                         wb_err
);

    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] c_zero_addr = AW'(RF_REG_ZERO);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [AW-1:0]    w_wr_addr [NWR];
    logic [XLEN-1:0]  w_wr_data [NWR];
    logic [NREGS-1:0] w_busy;

    for (genvar g = 0; g < NWR; g++) begin : g_wr_unpack
        assign w_wr_addr[g] = wr_addr[g*AW +: AW];
        assign w_wr_data[g] = wr_data[g*XLEN +: XLEN];
    end

    // Ascending port order: the last non-blocking assignment, i.e. the
    // highest-index port, wins a collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= XLEN'(RF_RESET_VALUE);
            end
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && w_wr_addr[w] != c_zero_addr) begin
                    r_regs[w_wr_addr[w]] <= w_wr_data[w];
                end
            end
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   w_rd_addr;
        logic [XLEN-1:0] w_rd_val;

        assign w_rd_addr = rd_addr[p*AW +: AW];

        always_comb begin
            w_rd_val = r_regs[w_rd_addr];
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && w_wr_addr[w] == w_rd_addr) begin
                    w_rd_val = w_wr_data[w];
                end
            end
            if (w_rd_addr == c_zero_addr) begin
                w_rd_val = '0;
            end
        end

        assign rd_data[p*XLEN +: XLEN] = w_rd_val;
        assign rd_busy[p]              = w_busy[w_rd_addr];
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR),
        .AW    (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .busy       (w_busy),
        .wb_err     (wb_err)
    );

endmodule

`default_nettype wire
